// File: rtl/tl_pkg.sv
// tl_pkg: shared link-state encodings and arbitration mode constants for the transaction layer
package tl_pkg;
  localparam int ST_W = 4;
  localparam logic [ST_W-1:0] ST_RESET  = 4'b0001;
  localparam logic [ST_W-1:0] ST_INIT   = 4'b0010;
  localparam logic [ST_W-1:0] ST_IDLE   = 4'b0100;
  localparam logic [ST_W-1:0] ST_ACTIVE = 4'b1000;
  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;
  function automatic logic xfer_state(input logic [ST_W-1:0] s);
    return s == ST_IDLE || s == ST_ACTIVE;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational first-requester search from a start pointer, or from 0 in fixed mode
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  start,
  input  logic              mode,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);
  int base;
  always_comb begin
    any  = |req;
    base = (mode || int'(start) >= NUM_CH) ? 0 : int'(start);
    idx  = '0;
    // scan farthest offset first so the nearest requester is written last
    for (int o = NUM_CH - 1; o >= 0; o--)
      if (req[(base + o) % NUM_CH]) idx = IDX_W'((base + o) % NUM_CH);
    gnt = any ? NUM_CH'(1) << idx : '0;
  end
endmodule

// File: rtl/vc_arb_mux.sv
// vc_arb_mux: drains one word per cycle from NUM_CH VC FIFOs into the downstream FIFO,
// gated by link state and backpressure, with round-robin or fixed-priority selection
module vc_arb_mux import tl_pkg::*; #(
  parameter int DATA_W = 6,
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 3,
  parameter int MODE   = 0,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic [ST_W-1:0]          state,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH-1:0]        empty,
  input  logic                     dest_full,
  output logic [NUM_CH-1:0]        pop,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  output logic [IDX_W-1:0]         grant_idx,
  output logic [CNT_W-1:0]         tx_count
);
  logic [IDX_W-1:0]  rr_ptr, cand;
  logic [NUM_CH-1:0] gnt;
  logic              any, xfer_en;
  rr_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .req(~empty),
    .start(rr_ptr),
    .mode(MODE == MODE_FIXED),
    .gnt(gnt),
    .idx(cand),
    .any(any)
  );
  assign xfer_en = reset_L && xfer_state(state) && !dest_full && any;
  assign pop = xfer_en ? gnt : '0;
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L || state == ST_RESET) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      grant_idx <= '0;
      rr_ptr    <= '0;
      tx_count  <= '0;
    end else if (xfer_en) begin
      data_out  <= data_in[int'(cand)*DATA_W +: DATA_W];
      valid_out <= 1'b1;
      grant_idx <= cand;
      rr_ptr    <= cand == IDX_W'(NUM_CH - 1) ? '0 : cand + 1'b1;
      tx_count  <= &tx_count ? tx_count : tx_count + 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
endmodule

// File: tb/tb_vc_arb_mux.sv
// tb_vc_arb_mux: scoreboard bench over three parameterisations (RR/4ch, RR/5ch, fixed/4ch with 4-bit counter)
module tb_vc_arb_mux;
  import tl_pkg::*;
  typedef struct {int vo; int dat; int idx; int cnt;} exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_L, dest_full;
  logic [3:0] st0, st1, st2;
  logic [3:0] em0, em2;
  logic [4:0] em1;
  logic [23:0] d0, d2;
  logic [29:0] d1;
  logic [3:0] p0, p2;
  logic [4:0] p1;
  logic [5:0] do0, do1, do2;
  logic vo0, vo1, vo2;
  logic [2:0] gi0, gi1, gi2;
  logic [15:0] tc0, tc1;
  logic [3:0] tc2;
  vc_arb_mux #(.DATA_W(6), .NUM_CH(4), .IDX_W(3), .MODE(0), .CNT_W(16)) u0 (
    .clk(clk), .reset_L(reset_L), .state(st0), .data_in(d0), .empty(em0), .dest_full(dest_full),
    .pop(p0), .data_out(do0), .valid_out(vo0), .grant_idx(gi0), .tx_count(tc0));
  vc_arb_mux #(.DATA_W(6), .NUM_CH(5), .IDX_W(3), .MODE(0), .CNT_W(16)) u1 (
    .clk(clk), .reset_L(reset_L), .state(st1), .data_in(d1), .empty(em1), .dest_full(dest_full),
    .pop(p1), .data_out(do1), .valid_out(vo1), .grant_idx(gi1), .tx_count(tc1));
  vc_arb_mux #(.DATA_W(6), .NUM_CH(4), .IDX_W(3), .MODE(1), .CNT_W(4)) u2 (
    .clk(clk), .reset_L(reset_L), .state(st2), .data_in(d2), .empty(em2), .dest_full(dest_full),
    .pop(p2), .data_out(do2), .valid_out(vo2), .grant_idx(gi2), .tx_count(tc2));
  int sel = 0;
  int n_chk = 0, n_pass = 0;
  int n_ch[3] = '{4, 5, 4};
  int cmax[3] = '{65535, 65535, 15};
  int mmode[3] = '{0, 0, 1};
  int dbase[3] = '{1, 16, 32};
  int ptr[3], cnt[3], mdat[3], midx[3];
  exp_t q[$];
  logic [7:0] cur_pop, cur_em;
  logic [3:0] cur_st;
  int cur_vo, cur_do, cur_gi, cur_tc;
  always_comb begin
    cur_pop = sel == 0 ? 8'(p0) : sel == 1 ? 8'(p1) : 8'(p2);
    cur_em  = sel == 0 ? 8'(em0) : sel == 1 ? 8'(em1) : 8'(em2);
    cur_st  = sel == 0 ? st0 : sel == 1 ? st1 : st2;
    cur_vo  = sel == 0 ? int'(vo0) : sel == 1 ? int'(vo1) : int'(vo2);
    cur_do  = sel == 0 ? int'(do0) : sel == 1 ? int'(do1) : int'(do2);
    cur_gi  = sel == 0 ? int'(gi0) : sel == 1 ? int'(gi1) : int'(gi2);
    cur_tc  = sel == 0 ? int'(tc0) : sel == 1 ? int'(tc1) : int'(tc2);
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask
  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      ptr[s] = 0; cnt[s] = 0; mdat[s] = 0; midx[s] = 0;
    end
  endtask
  task automatic set_in(input int s, input logic [7:0] e, input logic [3:0] stv);
    sel = s;
    st0 = s == 0 ? stv : ST_INIT;
    st1 = s == 1 ? stv : ST_INIT;
    st2 = s == 2 ? stv : ST_INIT;
    if (s == 0) em0 = e[3:0];
    if (s == 1) em1 = e[4:0];
    if (s == 2) em2 = e[3:0];
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, ".pop"}, 32'(|{p0, p1, p2}), 0);
    chk({tag, ".vo"}, 32'(vo0 | vo1 | vo2), 0);
    chk({tag, ".do"}, 32'(|{do0, do1, do2}), 0);
    chk({tag, ".gi"}, 32'(|{gi0, gi1, gi2}), 0);
    chk({tag, ".tc"}, 32'(|{tc0, tc1, tc2}), 0);
  endtask
  task automatic step(input string tag);
    int c, n, st0k;
    bit en;
    exp_t e;
    #1;
    n = n_ch[sel];
    c = -1;
    for (int o = 0; o < n; o++) begin
      int k;
      k = ((mmode[sel] == 1 ? 0 : ptr[sel]) + o) % n;
      if (c < 0 && !cur_em[k]) c = k;
    end
    st0k = (cur_st == ST_IDLE || cur_st == ST_ACTIVE) ? 1 : 0;
    en = st0k == 1 && !dest_full && c >= 0;
    chk({tag, ".pop"}, 32'(cur_pop), en ? 32'(1) << c : 0);
    if (cur_st == ST_RESET) begin
      ptr[sel] = 0; cnt[sel] = 0; mdat[sel] = 0; midx[sel] = 0; e.vo = 0;
    end else if (en) begin
      mdat[sel] = dbase[sel] + c;
      midx[sel] = c;
      ptr[sel] = (c + 1) % n;
      if (cnt[sel] < cmax[sel]) cnt[sel]++;
      e.vo = 1;
    end else e.vo = 0;
    e.dat = mdat[sel]; e.idx = midx[sel]; e.cnt = cnt[sel];
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".vo"}, cur_vo, e.vo);
    chk({tag, ".do"}, cur_do, e.dat);
    chk({tag, ".gi"}, cur_gi, e.idx);
    chk({tag, ".tc"}, cur_tc, e.cnt);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 4; k++) d0[k*6 +: 6] = 6'(dbase[0] + k);
    for (int k = 0; k < 5; k++) d1[k*6 +: 6] = 6'(dbase[1] + k);
    for (int k = 0; k < 4; k++) d2[k*6 +: 6] = 6'(dbase[2] + k);
    reset_L = 1'b0;
    dest_full = 1'($urandom);
    st0 = ST_ACTIVE; st1 = ST_IDLE; st2 = ST_ACTIVE;
    em0 = 4'($urandom); em1 = 5'($urandom); em2 = 4'($urandom);
    model_reset();
    #12;
    rst_chk("rst");
    dest_full = 1'b0;
    set_in(0, 8'h00, ST_RESET);
    st1 = ST_RESET; st2 = ST_RESET;
    reset_L = 1'b1;
    repeat (2) step("rst_state");
    set_in(0, 8'h00, ST_IDLE);
    repeat (5) step("rr");
    chk("rr.count", 32'(tc0), 5);
    dest_full = 1'b1;
    repeat (3) step("dfull");
    dest_full = 1'b0;
    repeat (2) step("resume");
    set_in(0, 8'h00, ST_INIT);
    repeat (3) step("init");
    set_in(0, 8'h00, ST_IDLE);
    repeat (2) step("resume2");
    set_in(0, 8'b0010, ST_ACTIVE);
    step("skip_cand");
    reset_L = 1'b0;
    #1;
    rst_chk("async");
    model_reset();
    reset_L = 1'b1;
    set_in(0, 8'h00, ST_IDLE);
    repeat (2) step("restart");
    set_in(0, 8'h00, ST_RESET);
    step("sync_clr");
    set_in(1, 8'b01010, ST_ACTIVE);
    repeat (5) step("wrap");
    set_in(2, 8'b0101, ST_IDLE);
    repeat (3) step("fixed");
    set_in(2, 8'b0111, ST_IDLE);
    step("fixed3");
    set_in(2, 8'b1100, 4'b1100);
    step("bad_state");
    set_in(2, 8'h00, ST_ACTIVE);
    repeat (16) step("sat");
    chk("sat.count", 32'(tc2), 15);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
